// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises I-cache line fills and D-cache fills/write-backs
// onto a single main-memory port, with registered response pulses and a sticky timeout flag.
module mem_arbiter #(
    parameter int ADDR_W  = 26,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    // I-cache side
    input  logic              reqI_mem,
    input  logic [ADDR_W-1:0] reqAddrI_mem,
    output logic [LINE_W-1:0] instr_from_mem,
    output logic              read_ready_I,
    // D-cache side
    input  logic              reqD_mem,
    input  logic              reqD_write,
    input  logic [ADDR_W-1:0] reqAddrD_mem,
    input  logic [LINE_W-1:0] dataD_to_mem,
    output logic [LINE_W-1:0] data_from_mem_D,
    output logic              read_ready_D,
    output logic              written_data_ack_D,
    // memory side
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              mem_wack,
    output logic              mem_error
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last_d;
    logic [7:0] timer;
    logic       grant_i;
    logic       resp_hit;

    // On a tie the requester that did not win last time is served.
    assign grant_i  = reqI_mem && (!reqD_mem || last_d);

    // Only the response kind matching the outstanding transaction completes it.
    assign resp_hit = ((state == BUSY_I) && mem_ready) ||
                      ((state == BUSY_D) && (mem_write ? mem_wack : mem_ready));

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            last_d             <= 1'b1;
            timer              <= '0;
            mem_req            <= 1'b0;
            mem_write          <= 1'b0;
            mem_addr           <= '0;
            mem_wdata          <= '0;
            mem_error          <= 1'b0;
            instr_from_mem     <= '0;
            data_from_mem_D    <= '0;
            read_ready_I       <= 1'b0;
            read_ready_D       <= 1'b0;
            written_data_ack_D <= 1'b0;
        end else begin
            // NOTE: pulses default low each cycle; a later assignment in this block overrides it.
            read_ready_I       <= 1'b0;
            read_ready_D       <= 1'b0;
            written_data_ack_D <= 1'b0;

            case (state)
                IDLE: begin
                    timer <= '0;
                    if (grant_i) begin
                        mem_addr  <= reqAddrI_mem;
                        mem_write <= 1'b0;
                        mem_req   <= 1'b1;
                        last_d    <= 1'b0;
                        state     <= BUSY_I;
                    end else if (reqD_mem) begin
                        mem_addr  <= reqAddrD_mem;
                        mem_wdata <= dataD_to_mem;
                        mem_write <= reqD_write;
                        mem_req   <= 1'b1;
                        last_d    <= 1'b1;
                        state     <= BUSY_D;
                    end
                end

                BUSY_I, BUSY_D: begin
                    if (resp_hit) begin
                        mem_req <= 1'b0;
                        state   <= RELEASE;
                        if (state == BUSY_I) begin
                            instr_from_mem <= mem_rdata;
                            read_ready_I   <= 1'b1;
                        end else if (mem_write) begin
                            written_data_ack_D <= 1'b1;
                        end else begin
                            data_from_mem_D <= mem_rdata;
                            read_ready_D    <= 1'b1;
                        end
                    end else if (timer == TIMER_LAST) begin
                        // Abort silently; the stalled requester is left to the diagnostic flag.
                        mem_error <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= RELEASE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                RELEASE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level reference model predicts grant order
// and line data; a monitor checks every memory grant and every cache-side pulse against it.
module tb_mem_arbiter;

    localparam int ADDR_W  = 26;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 255;
    localparam int K_IRD   = 0;
    localparam int K_DRD   = 1;
    localparam int K_DWR   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              reqI_mem;
    logic [ADDR_W-1:0] reqAddrI_mem;
    logic [LINE_W-1:0] instr_from_mem;
    logic              read_ready_I;
    logic              reqD_mem;
    logic              reqD_write;
    logic [ADDR_W-1:0] reqAddrD_mem;
    logic [LINE_W-1:0] dataD_to_mem;
    logic [LINE_W-1:0] data_from_mem_D;
    logic              read_ready_D;
    logic              written_data_ack_D;
    logic              mem_req;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              mem_wack;
    logic              mem_error;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .reqI_mem(reqI_mem), .reqAddrI_mem(reqAddrI_mem),
        .instr_from_mem(instr_from_mem), .read_ready_I(read_ready_I),
        .reqD_mem(reqD_mem), .reqD_write(reqD_write), .reqAddrD_mem(reqAddrD_mem),
        .dataD_to_mem(dataD_to_mem), .data_from_mem_D(data_from_mem_D),
        .read_ready_D(read_ready_D), .written_data_ack_D(written_data_ack_D),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_wack(mem_wack), .mem_error(mem_error)
    );

    typedef struct {
        int                kind;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } txn_t;

    txn_t grant_q[$];
    txn_t resp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   resp_cyc = -10;
    int   rst_epoch = 0;

    // memory-model controls, written only by the stimulus process
    int                lat = 2;
    bit                resp_en = 1'b1;
    bit                inject_en = 1'b0;
    int                force_req = 0;
    logic [ADDR_W-1:0] pre_addr = 26'h10;
    logic [LINE_W-1:0] pre_data = {32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D, 32'hDEADBEEF};

    // reference model state, written only by the stimulus process
    logic [LINE_W-1:0] ref_mem [logic [ADDR_W-1:0]];
    bit                last_was_d = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] init_line(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        return {w ^ 32'h5A5A_5A5A, ~w, w * 32'd3, w + 32'd7};
    endfunction

    // Memory responder: answers after lat waiting cycles, optionally spraying wrong-kind strobes.
    initial begin
        logic [LINE_W-1:0] store [logic [ADDR_W-1:0]];
        int wait_cnt;
        int force_seen;
        wait_cnt = 0;
        force_seen = 0;
        mem_ready = 1'b0;
        mem_wack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_wack = 1'b0;
            if (force_req != force_seen) begin
                force_seen = force_req;
                mem_ready = 1'b1;
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end else if (mem_req && resp_en) begin
                if (wait_cnt >= lat) begin
                    wait_cnt = 0;
                    resp_cyc = cyc;
                    if (mem_write) begin
                        mem_wack = 1'b1;
                        store[mem_addr] = mem_wdata;
                    end else begin
                        mem_ready = 1'b1;
                        if (store.exists(mem_addr))  mem_rdata = store[mem_addr];
                        else if (mem_addr == pre_addr) mem_rdata = pre_data;
                        else                          mem_rdata = init_line(mem_addr);
                    end
                end else begin
                    wait_cnt++;
                    if (inject_en && $urandom_range(3) == 0) begin
                        if (mem_write) begin
                            mem_ready = 1'b1;
                            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                        end else begin
                            mem_wack = 1'b1;
                        end
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pops the grant queue on each mem_req rise and the response queue on each pulse.
    initial begin
        bit                prev_req;
        txn_t              cur;
        txn_t              exp;
        int                seen_epoch;
        int                npulse;
        int                act_kind;
        logic [LINE_W-1:0] last_i;
        logic [LINE_W-1:0] last_d;
        prev_req = 1'b0;
        seen_epoch = 0;
        last_i = '0;
        last_d = '0;
        cur.kind = K_IRD;
        cur.addr = '0;
        cur.data = '0;
        forever begin
            @(negedge clk);
            if (rst_epoch != seen_epoch) begin
                seen_epoch = rst_epoch;
                last_i = '0;
                last_d = '0;
            end
            if (mem_req && !prev_req) begin
                check("grant_expected", LINE_W'(grant_q.size() != 0), 1);
                if (grant_q.size() != 0) begin
                    cur = grant_q.pop_front();
                    check("grant_write", mem_write, LINE_W'(cur.kind == K_DWR));
                    if (cur.kind == K_DWR) check("grant_wdata", mem_wdata, cur.data);
                end
            end
            if (mem_req) check("mem_addr", mem_addr, cur.addr);
            prev_req = mem_req;

            npulse = int'(read_ready_I) + int'(read_ready_D) + int'(written_data_ack_D);
            if (npulse != 0) begin
                check("one_pulse", npulse, 1);
                check("pulse_expected", LINE_W'(resp_q.size() != 0), 1);
                check("resp_latency", cyc, resp_cyc + 1);
                check("req_dropped", mem_req, 0);
                if (resp_q.size() != 0) begin
                    exp = resp_q.pop_front();
                    act_kind = read_ready_I ? K_IRD : (read_ready_D ? K_DRD : K_DWR);
                    check("resp_kind", act_kind, exp.kind);
                    if (exp.kind == K_IRD) begin
                        check("instr_data", instr_from_mem, exp.data);
                        last_i = exp.data;
                        check("d_data_hold", data_from_mem_D, last_d);
                    end else if (exp.kind == K_DRD) begin
                        check("d_data", data_from_mem_D, exp.data);
                        last_d = exp.data;
                        check("i_data_hold", instr_from_mem, last_i);
                    end else begin
                        check("i_data_hold", instr_from_mem, last_i);
                        check("d_data_hold", data_from_mem_D, last_d);
                    end
                end
            end
        end
    end

    // Reference model: one transaction, predicted data, round-robin bookkeeping.
    task automatic plan(input int kind, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd,
                        input bit expect_resp);
        txn_t t;
        t.kind = kind;
        t.addr = a;
        t.data = wd;
        grant_q.push_back(t);
        if (kind == K_DWR) ref_mem[a] = wd;
        else t.data = ref_mem.exists(a) ? ref_mem[a] : init_line(a);
        if (expect_resp) resp_q.push_back(t);
        last_was_d = (kind != K_IRD);
    endtask

    task automatic run_round(input bit do_i, input bit do_d, input bit d_wr,
                             input logic [ADDR_W-1:0] ai, input logic [ADDR_W-1:0] ad,
                             input logic [LINE_W-1:0] wd, input bit scramble);
        int dk;
        dk = d_wr ? K_DWR : K_DRD;
        @(negedge clk);
        if (do_i && do_d) begin
            if (last_was_d) begin
                plan(K_IRD, ai, '0, 1'b1);
                plan(dk, ad, wd, 1'b1);
            end else begin
                plan(dk, ad, wd, 1'b1);
                plan(K_IRD, ai, '0, 1'b1);
            end
        end else if (do_i) begin
            plan(K_IRD, ai, '0, 1'b1);
        end else if (do_d) begin
            plan(dk, ad, wd, 1'b1);
        end
        reqAddrI_mem = ai;
        reqAddrD_mem = ad;
        dataD_to_mem = wd;
        reqD_write = d_wr;
        reqI_mem = do_i;
        reqD_mem = do_d;
        for (int n = 0; n < 400 && (reqI_mem || reqD_mem); n++) begin
            @(negedge clk);
            if (n == 0) check("req_to_mem_req", mem_req, 1);
            if (read_ready_I) reqI_mem = 1'b0;
            if (read_ready_D || written_data_ack_D) reqD_mem = 1'b0;
            if (scramble && reqI_mem) reqAddrI_mem = ADDR_W'($urandom);
        end
        check("round_done", LINE_W'(reqI_mem || reqD_mem), 0);
        reqI_mem = 1'b0;
        reqD_mem = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_instr", instr_from_mem, 0);
        check("rst_data_d", data_from_mem_D, 0);
        check("rst_pulses", {read_ready_I, read_ready_D, written_data_ack_D}, 0);
        check("rst_mem_error", mem_error, 0);
    endtask

    initial begin
        int hi;
        int n;
        txn_t t;
        reset = 1'b1;
        reqI_mem = 1'b0;
        reqD_mem = 1'b0;
        reqD_write = 1'b0;
        reqAddrI_mem = '0;
        reqAddrD_mem = '0;
        dataD_to_mem = '0;
        ref_mem[26'h10] = pre_data;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        // single I read and single D write-back
        lat = 3;
        run_round(1'b1, 1'b0, 1'b0, 26'h10, '0, '0, 1'b0);
        lat = 2;
        run_round(1'b0, 1'b1, 1'b1, '0, 26'h3FF_FFFF, {16{8'hA5}}, 1'b0);

        // address wiggling while the I fill is outstanding
        lat = 4;
        run_round(1'b1, 1'b0, 1'b0, 26'h123_4560, '0, '0, 1'b1);

        // memory never answers
        resp_en = 1'b0;
        @(negedge clk);
        t.kind = K_IRD;
        t.addr = 26'h0AB_CDE0;
        t.data = '0;
        grant_q.push_back(t);
        last_was_d = 1'b0;
        reqAddrI_mem = t.addr;
        reqI_mem = 1'b1;
        hi = 0;
        n = 0;
        while (n < 600 && !(hi > 0 && !mem_req)) begin
            @(negedge clk);
            n++;
            if (mem_req) hi++;
        end
        reqI_mem = 1'b0;
        check("timeout_cycles", hi, TIMEOUT);
        check("mem_error_set", mem_error, 1);
        resp_en = 1'b1;
        run_round(1'b0, 1'b1, 1'b0, '0, 26'h10, '0, 1'b0);
        check("mem_error_sticky", mem_error, 1);

        // reset in the middle of a D read, followed by a late mem_ready
        resp_en = 1'b0;
        @(negedge clk);
        t.kind = K_DRD;
        t.addr = 26'h000_0040;
        t.data = '0;
        grant_q.push_back(t);
        reqAddrD_mem = t.addr;
        reqD_write = 1'b0;
        reqD_mem = 1'b1;
        repeat (6) @(negedge clk);
        check("busy_before_reset", mem_req, 1);
        reset = 1'b1;
        reqD_mem = 1'b0;
        rst_epoch++;
        @(negedge clk);
        reset = 1'b0;
        last_was_d = 1'b1;
        force_req++;
        check_reset_outputs();
        repeat (3) begin
            @(negedge clk);
            check("late_ready_ignored", {mem_req, read_ready_D}, 0);
        end
        resp_en = 1'b1;

        // both requesters held from reset: grants alternate I, D, I, D, ...
        for (int r = 0; r < 4; r++) begin
            lat = r + 1;
            run_round(1'b1, 1'b1, r[0], 26'h100 + ADDR_W'(r), 26'h200 + ADDR_W'(r),
                      {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end

        // randomized traffic with wrong-kind strobes; small address pool for read-after-write
        inject_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            int  mode;
            bit  di;
            bit  dd;
            mode = $urandom_range(2);
            di = (mode != 1);
            dd = (mode != 0);
            lat = $urandom_range(5);
            run_round(di, dd, 1'($urandom), ADDR_W'($urandom_range(7) * 8),
                      ADDR_W'($urandom_range(7) * 8),
                      {$urandom, $urandom, $urandom, $urandom}, di && !dd);
        end
        inject_en = 1'b0;

        repeat (4) @(negedge clk);
        check("grant_q_drained", grant_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
        check("mem_error_final", mem_error, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
